// File: rtl/btn_pkg.sv
// Shared types and helpers for the shared-timer button debouncer.
// Optional event latch is enabled by defining BTN_EVENT_LATCH_EN.
package btn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce_sched_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous inputs.
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_sched.sv
// N-button debouncer sharing one timer through a round-robin arbiter.
// Define BTN_EVENT_LATCH_EN to add evt_ack/evt_pending press latches.
module btn_debounce_sched
    import btn_pkg::*;
#(
    parameter  int N_BTN           = 4,
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W           = clog2(DEBOUNCE_CYCLES),
    localparam int IDX_W           = (N_BTN > 1) ? clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_stable,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
`ifdef BTN_EVENT_LATCH_EN
    ,
    input  logic [N_BTN-1:0] evt_ack,
    output logic [N_BTN-1:0] evt_pending
`endif
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] grant_n;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] mismatch;
    logic [N_BTN-1:0] stable_n;
    logic [N_BTN-1:0] press_n;
    logic [N_BTN-1:0] release_n;

    btn_sync #(
        .WIDTH (N_BTN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_raw),
        .dout  (sync)
    );

    assign mismatch = sync ^ btn_stable;
    assign busy     = (state == COUNT);

    // Round-robin scan starting just after the last served button.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_BTN) j = j - N_BTN;
            if (!found && mismatch[j]) begin
                found = 1'b1;
                cand  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        grant_n   = grant_idx;
        stable_n  = btn_stable;
        press_n   = '0;
        release_n = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = cand;
                    cnt_n   = '0;
                    state_n = COUNT;
                end
            end
            COUNT: begin
                if (sync[grant_idx] == btn_stable[grant_idx]) begin
                    ptr_n   = grant_idx;
                    state_n = IDLE;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_n[grant_idx]  = sync[grant_idx];
                    press_n[grant_idx]   = sync[grant_idx];
                    release_n[grant_idx] = ~sync[grant_idx];
                    ptr_n                = grant_idx;
                    state_n              = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= IDX_W'(N_BTN - 1);
            grant_idx   <= '0;
            btn_stable  <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ptr         <= ptr_n;
            grant_idx   <= grant_n;
            btn_stable  <= stable_n;
            btn_press   <= press_n;
            btn_release <= release_n;
        end
    end

`ifdef BTN_EVENT_LATCH_EN
    // A press arriving with an ack keeps the latch set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pending <= '0;
        end else begin
            evt_pending <= (evt_pending & ~evt_ack) | btn_press;
        end
    end
`endif

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Self-checking bench for btn_debounce_sched (N_BTN=4, DEBOUNCE_CYCLES=16).
// Define BTN_EVENT_LATCH_EN to also exercise the event latch.
module tb_btn_debounce_sched;

    localparam int N = 4;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_stable;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       busy;
    logic [1:0] grant_idx;
`ifdef BTN_EVENT_LATCH_EN
    logic [3:0] evt_ack = '0;
    logic [3:0] evt_pending;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;
    ev_t evq[$];

    always #5 clk = ~clk;

    btn_debounce_sched #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_stable  (btn_stable),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .busy        (busy),
        .grant_idx   (grant_idx)
`ifdef BTN_EVENT_LATCH_EN
        ,
        .evt_ack     (evt_ack),
        .evt_pending (evt_pending)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ((btn_press | btn_release) != 4'b0))
            evq.push_back('{cyc, btn_press, btn_release});
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Reference model: sync is raw delayed two edges; a granted button
    // commits D edges after its grant unless its level returns first.
    typedef struct {
        logic [3:0] dly;
        logic [3:0] sync;
        logic [3:0] stable;
        logic [3:0] press;
        logic [3:0] rel;
        int         owner;
        int         gcyc;
        int         ptr;
        int         grant;
        int         cyc;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.dly = '0; r.sync = '0; r.stable = '0;
        r.press = '0; r.rel = '0;
        r.owner = -1; r.gcyc = 0; r.ptr = N - 1;
        r.grant = 0; r.cyc = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic [3:0] raw);
        mdl_t n;
        n = s;
        n.cyc = s.cyc + 1;
        n.press = '0;
        n.rel = '0;
        if (s.owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (s.ptr + k) % N;
                if (n.owner < 0 && s.sync[j] !== s.stable[j]) begin
                    n.owner = j;
                    n.grant = j;
                    n.gcyc = n.cyc;
                end
            end
        end else if (s.sync[s.owner] === s.stable[s.owner]) begin
            n.ptr = s.owner;
            n.owner = -1;
        end else if (n.cyc - s.gcyc == D) begin
            n.stable[s.owner] = s.sync[s.owner];
            if (s.sync[s.owner]) n.press[s.owner] = 1'b1;
            else n.rel[s.owner] = 1'b1;
            n.ptr = s.owner;
            n.owner = -1;
        end
        n.sync = s.dly;
        n.dly = raw;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_reset();
        else m <= mdl_step(m, btn_raw);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (btn_stable !== 4'b0) begin
            errors++;
            $display("FAIL reset_stable got %b want 0000", btn_stable);
        end
        checks++;
        if ((btn_press | btn_release) !== 4'b0) begin
            errors++;
            $display("FAIL reset_pulse got %b/%b want 0", btn_press, btn_release);
        end
        checks++;
        if (busy !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_busy_grant got %b/%0d want 0/0", busy, grant_idx);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clean_press();
        int t0, got;
        evq.delete();
        busy_cnt = 0;
        btn_raw[1] = 1'b1;
        t0 = cyc;
        tick(25);
        got = (evq.size() > 0) ? evq[0].cyc - t0 : -1;
        checks++;
        if (evq.size() != 1 || got != D + 3) begin
            errors++;
            $display("FAIL clean_latency got n=%0d at %0d want n=1 at %0d",
                     evq.size(), got, D + 3);
        end
        checks++;
        if (evq.size() > 0 && (evq[0].press !== 4'b0010 || evq[0].rel !== 4'b0)) begin
            errors++;
            $display("FAIL clean_pulse got %b/%b want 0010/0000",
                     evq[0].press, evq[0].rel);
        end
        checks++;
        if (busy_cnt != D) begin
            errors++;
            $display("FAIL clean_busy got %0d want %0d", busy_cnt, D);
        end
        checks++;
        if (btn_stable !== 4'b0010 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL clean_state got %b/%0d want 0010/1", btn_stable, grant_idx);
        end
    endtask

    task automatic test_bounce();
        int t0, got;
        evq.delete();
        for (int i = 0; i < 12; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick(5);
        end
        btn_raw[0] = 1'b1;
        t0 = cyc;
        tick(25);
        got = (evq.size() > 0) ? evq[0].cyc - t0 : -1;
        checks++;
        if (evq.size() != 1 || got != D + 3) begin
            errors++;
            $display("FAIL bounce_latency got n=%0d at %0d want n=1 at %0d",
                     evq.size(), got, D + 3);
        end
        checks++;
        if (evq.size() > 0 && evq[0].press !== 4'b0001) begin
            errors++;
            $display("FAIL bounce_pulse got %b want 0001", evq[0].press);
        end
        checks++;
        if (btn_stable !== 4'b0011) begin
            errors++;
            $display("FAIL bounce_stable got %b want 0011", btn_stable);
        end
    endtask

    task automatic test_contention();
        int t0, got;
        int         exp_t[3];
        logic [3:0] exp_p[3];
        exp_t = '{D + 3, 2 * D + 4, 3 * D + 5};
        exp_p = '{4'b0001, 4'b0100, 4'b1000};
        btn_raw = '0;
        do_reset();
        evq.delete();
        btn_raw = 4'b1101;
        t0 = cyc;
        tick(60);
        checks++;
        if (evq.size() != 3) begin
            errors++;
            $display("FAIL contention_count got %0d want 3", evq.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < evq.size()) ? evq[i].cyc - t0 : -1;
            checks++;
            if (got != exp_t[i] || (i < evq.size() && evq[i].press !== exp_p[i])) begin
                errors++;
                $display("FAIL contention_commit%0d got %0d want %0d press %b",
                         i, got, exp_t[i], exp_p[i]);
            end
        end
        evq.delete();
        btn_raw = 4'b1000;
        t0 = cyc;
        tick(45);
        exp_p = '{4'b0001, 4'b0100, 4'b0000};
        for (int i = 0; i < 2; i++) begin
            got = (i < evq.size()) ? evq[i].cyc - t0 : -1;
            checks++;
            if (got != exp_t[i] || (i < evq.size() && evq[i].rel !== exp_p[i])) begin
                errors++;
                $display("FAIL fair_release%0d got %0d want %0d rel %b",
                         i, got, exp_t[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_release();
        int t0, got;
        btn_raw[2] = 1'b1;
        tick(25);
        evq.delete();
        btn_raw[2] = 1'b0;
        t0 = cyc;
        tick(25);
        got = (evq.size() > 0) ? evq[0].cyc - t0 : -1;
        checks++;
        if (evq.size() != 1 || got != D + 3) begin
            errors++;
            $display("FAIL release_latency got n=%0d at %0d want n=1 at %0d",
                     evq.size(), got, D + 3);
        end
        checks++;
        if (evq.size() > 0 && (evq[0].rel !== 4'b0100 || evq[0].press !== 4'b0)) begin
            errors++;
            $display("FAIL release_pulse got %b/%b want 0000/0100",
                     evq[0].press, evq[0].rel);
        end
        checks++;
        if (btn_stable !== 4'b1000) begin
            errors++;
            $display("FAIL release_stable got %b want 1000", btn_stable);
        end
    endtask

    task automatic test_reset_mid();
        int t1, got;
        evq.delete();
        btn_raw = 4'b1010;
        tick(11);
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL midreset_pre got %b/%0d want 1/1", busy, grant_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (btn_stable !== 4'b0 || busy !== 1'b0 || grant_idx !== 2'd0 ||
            (btn_press | btn_release) !== 4'b0) begin
            errors++;
            $display("FAIL midreset_async got %b/%b/%0d want 0000/0/0",
                     btn_stable, busy, grant_idx);
        end
        tick(2);
        rst_n = 1'b1;
        t1 = cyc;
        tick(40);
        checks++;
        if (evq.size() != 2) begin
            errors++;
            $display("FAIL midreset_count got %0d want 2", evq.size());
        end
        got = (evq.size() > 0) ? evq[0].cyc - t1 : -1;
        checks++;
        if (got != D + 3 || (evq.size() > 0 && evq[0].press !== 4'b0010)) begin
            errors++;
            $display("FAIL midreset_recommit got %0d want %0d", got, D + 3);
        end
        checks++;
        if (btn_stable !== 4'b1010) begin
            errors++;
            $display("FAIL midreset_stable got %b want 1010", btn_stable);
        end
    endtask

    task automatic test_random();
        btn_raw = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 29) == 0) btn_raw[b] = ~btn_raw[b];
            @(negedge clk);
            checks++;
            if (btn_stable !== m.stable || btn_press !== m.press ||
                btn_release !== m.rel) begin
                errors++;
                $display("FAIL rand_out c=%0d got %b/%b/%b want %b/%b/%b", c,
                         btn_stable, btn_press, btn_release,
                         m.stable, m.press, m.rel);
            end
            checks++;
            if (busy !== (m.owner >= 0) || grant_idx !== 2'(m.grant)) begin
                errors++;
                $display("FAIL rand_arb c=%0d got %b/%0d want %b/%0d", c,
                         busy, grant_idx, m.owner >= 0, m.grant);
            end
            checks++;
            if ($countones(btn_press | btn_release) > 1) begin
                errors++;
                $display("FAIL rand_onehot c=%0d got %b/%b want <=1 bit",
                         c, btn_press, btn_release);
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef BTN_EVENT_LATCH_EN
    task automatic test_evt_latch();
        btn_raw = '0;
        evt_ack = '0;
        do_reset();
        btn_raw[3] = 1'b1;
        tick(22);
        checks++;
        if (evt_pending !== 4'b1000) begin
            errors++;
            $display("FAIL evt_set got %b want 1000", evt_pending);
        end
        tick(5);
        checks++;
        if (evt_pending !== 4'b1000) begin
            errors++;
            $display("FAIL evt_hold got %b want 1000", evt_pending);
        end
        evt_ack[3] = 1'b1;
        tick(1);
        evt_ack = '0;
        checks++;
        if (evt_pending !== 4'b0) begin
            errors++;
            $display("FAIL evt_clear got %b want 0000", evt_pending);
        end
        btn_raw[3] = 1'b0;
        tick(25);
        btn_raw[3] = 1'b1;
        tick(D + 3);
        evt_ack[3] = 1'b1;
        tick(1);
        evt_ack = '0;
        checks++;
        if (evt_pending !== 4'b1000) begin
            errors++;
            $display("FAIL evt_set_wins got %b want 1000", evt_pending);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_contention();
        test_release();
        test_reset_mid();
        test_random();
`ifdef BTN_EVENT_LATCH_EN
        test_evt_latch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
